// File: rtl/uart_rx_fifo.sv
// UART receiver with 2-flop input synchroniser, parity/framing checks and a
// first-word fall-through receive FIFO with overrun reporting.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 32,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] ReadData,
  output logic                 ReadParityErr,
  output logic                 ReadFrameErr,
  output logic                 DataValid,
  input  logic                 ReadAck,
  output logic                 Overrun,
  input  logic                 ClearOverrun,
  output logic                 Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;

  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] IDX_ONE  = BW'(1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_WRITE  = 3'd5;

  logic                 rx_meta_reg, rx_s_reg;
  logic [2:0]           state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [BW-1:0]        bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 perr_reg, perr_next;
  logic                 ferr_reg, ferr_next;
  logic                 brk_reg, brk_next;
  logic                 push;

  logic [EW-1:0]        mem_reg [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic                 valid_reg, ovr_reg;
  logic                 full, pop, wr_en, ovr_event;
  logic [EW-1:0]        head;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + CNT_ONE;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    perr_next    = perr_reg;
    ferr_next    = ferr_reg;
    brk_next     = brk_reg;
    push         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        // After a framing error the line must return high before re-arming.
        if (brk_reg) begin
          if (rx_s_reg) brk_next = 1'b0;
        end else if (!rx_s_reg) begin
          state_next = ST_START;
          perr_next  = 1'b0;
          ferr_next  = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_reg == HALF_CNT) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_s_reg ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_reg == FULL_CNT) begin
          cnt_next   = '0;
          shift_next = {rx_s_reg, shift_reg[DATA_BITS-1:1]};
          if (bit_idx_reg == LAST_DATA) begin
            bit_idx_next = '0;
            state_next   = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + IDX_ONE;
          end
        end
      end
      ST_PARITY: begin
        if (cnt_reg == FULL_CNT) begin
          cnt_next   = '0;
          perr_next  = ((^shift_reg) ^ rx_s_reg) != (PARITY_MODE == 1);
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_reg == FULL_CNT) begin
          cnt_next = '0;
          if (!rx_s_reg) ferr_next = 1'b1;
          if (bit_idx_reg == LAST_STOP) state_next = ST_WRITE;
          else bit_idx_next = bit_idx_reg + IDX_ONE;
        end
      end
      ST_WRITE: begin
        push       = 1'b1;
        brk_next   = ferr_reg;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      perr_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
      brk_reg     <= 1'b0;
    end else begin
      rx_meta_reg <= RX;
      rx_s_reg    <= rx_meta_reg;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      perr_reg    <= perr_next;
      ferr_reg    <= ferr_next;
      brk_reg     <= brk_next;
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop       = ReadAck && valid_reg;
  assign wr_en     = push && (!full || pop);
  assign ovr_event = push && full && !pop;
  assign rd_ptr_next = pop ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;

  always_ff @(posedge Clock) begin
    if (wr_en) mem_reg[wr_ptr_reg[AW-1:0]] <= {ferr_reg, perr_reg, shift_reg};
  end

  // The valid flag sees pushes one cycle late but pops immediately, so it never overstates.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      valid_reg  <= 1'b0;
      ovr_reg    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      rd_ptr_reg <= rd_ptr_next;
      valid_reg  <= (wr_ptr_reg != rd_ptr_next);
      if (ovr_event) ovr_reg <= 1'b1;
      else if (ClearOverrun) ovr_reg <= 1'b0;
    end
  end

  assign head          = valid_reg ? mem_reg[rd_ptr_reg[AW-1:0]] : '0;
  assign ReadData      = head[DATA_BITS-1:0];
  assign ReadParityErr = head[DATA_BITS];
  assign ReadFrameErr  = head[DATA_BITS+1];
  assign DataValid     = valid_reg;
  assign Overrun       = ovr_reg;
  assign Busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance,
// each with its own expected-entry queue drained by an independent monitor.
module tb_uart_rx_fifo;
  localparam int CPB = 32;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic       rx0, rx1, ack0, ack1, clr0, clr1;
  logic [7:0] rd0, rd1;
  logic       perr0, perr1, ferr0, ferr1, dv0, dv1, ovr0, ovr1, busy0, busy1;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];
  bit auto_ack0 = 1'b1;
  bit auto_ack1 = 1'b1;

  always #5 Clock = ~Clock;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .RX(rx0), .ReadData(rd0),
    .ReadParityErr(perr0), .ReadFrameErr(ferr0), .DataValid(dv0),
    .ReadAck(ack0), .Overrun(ovr0), .ClearOverrun(clr0), .Busy(busy0));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_p (
    .Clock(Clock), .Reset_n(Reset_n), .RX(rx1), .ReadData(rd1),
    .ReadParityErr(perr1), .ReadFrameErr(ferr1), .DataValid(dv1),
    .ReadAck(ack1), .Overrun(ovr1), .ClearOverrun(clr1), .Busy(busy1));

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input bit sel, input bit b);
    if (sel) rx1 = b;
    else rx0 = b;
    repeat (CPB) @(negedge Clock);
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input bit use_par,
                      input bit par, input bit stop);
    drive(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive(sel, d[i]);
    if (use_par) drive(sel, par);
    drive(sel, stop);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic latency_watch();
    int n;
    n = 0;
    while (!busy0 && n < 100) begin @(negedge Clock); n++; end
    check("lat_busy_rise", busy0, 1);
    n = 0;
    while (busy0 && n < 400) begin @(negedge Clock); n++; end
    check("lat_busy_fall", busy0, 0);
    check("lat_dv_before", dv0, 0);
    @(negedge Clock);
    check("lat_dv_rise", dv0, 1);
    @(negedge Clock);
    check("ack_clears_dv", dv0, 0);
  endtask

  // Monitor for the 8N1 instance: compares and acknowledges the head entry.
  initial begin
    logic [9:0] got;
    ack0 = 1'b0;
    forever begin
      @(negedge Clock);
      ack0 = 1'b0;
      if (dv0 && auto_ack0) begin
        got = {ferr0, perr0, rd0};
        $display("RX0 entry %03h", got);
        if (exp_q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon0_unexpected actual=%03h required=none", got);
        end else begin
          check("mon0_entry", got, exp_q0.pop_front());
        end
        ack0 = 1'b1;
      end
    end
  end

  // Monitor for the even-parity instance.
  initial begin
    logic [9:0] got;
    ack1 = 1'b0;
    forever begin
      @(negedge Clock);
      ack1 = 1'b0;
      if (dv1 && auto_ack1) begin
        got = {ferr1, perr1, rd1};
        $display("RX1 entry %03h", got);
        if (exp_q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon1_unexpected actual=%03h required=none", got);
        end else begin
          check("mon1_entry", got, exp_q1.pop_front());
        end
        ack1 = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bc;
    int n;
    Reset_n = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
    idle(3);
    check("rst_dv", dv0, 0);
    check("rst_data", rd0, 0);
    check("rst_perr", perr0, 0);
    check("rst_ferr", ferr0, 0);
    check("rst_ovr", ovr0, 0);
    check("rst_busy", busy0, 0);
    Reset_n = 1'b1;
    idle(5);

    // 8N1 frame 0xA5 with latency and acknowledge checks.
    exp_q0.push_back({2'b00, 8'hA5});
    fork
      send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      latency_watch();
    join
    idle(20);

    // Even parity: correct parity bit, then a wrong one.
    exp_q1.push_back({2'b00, 8'h07});
    send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    exp_q1.push_back({2'b01, 8'h07});
    send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    idle(20);

    // Framing error followed by a long break: no new frame while the line is low.
    exp_q0.push_back({2'b10, 8'h55});
    send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    bc = 0;
    for (int i = 0; i < 40 * CPB; i++) begin
      @(negedge Clock);
      if (busy0) bc++;
    end
    check("break_busy_cycles", bc, 0);
    rx0 = 1'b1;
    idle(4 * CPB);
    exp_q0.push_back({2'b00, 8'h11});
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    idle(20);

    // 10-cycle low glitch is rejected at the half-bit sample.
    rx0 = 1'b0;
    bc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clock);
      if (i == 9) rx0 = 1'b1;
      if (busy0) bc++;
    end
    check("glitch_busy_window", (bc >= 14 && bc <= 18) ? 1 : 0, 1);
    idle(40);
    check("glitch_no_write", dv0, 0);

    // Five frames into a four-deep FIFO without acknowledging.
    auto_ack0 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q0.push_back({2'b00, 8'(k)});
      send(1'b0, 8'(k), 1'b0, 1'b0, 1'b1);
    end
    idle(10);
    check("ovr_set", ovr0, 1);
    check("ovr_dv", dv0, 1);
    check("ovr_head", rd0, 8'h01);
    auto_ack0 = 1'b1;
    n = 0;
    while (dv0 && n < 50) begin @(negedge Clock); n++; end
    idle(3);
    check("ovr_drain", exp_q0.size(), 0);
    check("ovr_sticky", ovr0, 1);
    clr0 = 1'b1;
    @(negedge Clock);
    clr0 = 1'b0;
    check("ovr_cleared", ovr0, 0);

    // Reset in the middle of data bit 3 discards both the FIFO and the frame.
    auto_ack0 = 1'b0;
    send(1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
    idle(5);
    check("pre_reset_dv", dv0, 1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    rx0 = 1'b1;
    idle(16);
    check("pre_reset_busy", busy0, 1);
    Reset_n = 1'b0;
    idle(2);
    check("mid_rst_dv", dv0, 0);
    check("mid_rst_data", rd0, 0);
    check("mid_rst_perr", perr0, 0);
    check("mid_rst_ferr", ferr0, 0);
    check("mid_rst_ovr", ovr0, 0);
    check("mid_rst_busy", busy0, 0);
    Reset_n = 1'b1;
    idle(2 * CPB);
    auto_ack0 = 1'b1;
    exp_q0.push_back({2'b00, 8'h3C});
    send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    idle(50);

    check("final_q0_empty", exp_q0.size(), 0);
    check("final_q1_empty", exp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
